// File: rtl/seq_ripple_subtractor.sv
// rtl/seq_ripple_subtractor.sv - multi-cycle unsigned subtractor, CHUNK bits per clock with rippled borrow
module seq_ripple_subtractor #(
  parameter int WIDTH = 40,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("seq_ripple_subtractor: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic [IW-1:0]    idx;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right one chunk per cycle; result chunks enter acc from the top,
  // so after the last chunk acc holds the full difference in place.
  always_comb begin
    chunk_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, ~b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, ~borrow};
    acc_next  = (acc >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      borrow     <= 1'b0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= minuend;
            b_sh     <= subtrahend;
            acc      <= '0;
            borrow   <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          acc    <= acc_next;
          borrow <= ~chunk_sum[CHUNK];
          idx    <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            diff       <= acc_next;
            borrow_out <= ~chunk_sum[CHUNK];
            zero       <= (acc_next == '0);
            out_valid  <= 1'b1;
            idx        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
